// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops, result flags, pass-through tag,
// valid/ready flow control on both sides and a saturating completion counter.
module logic_unit_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dst,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] done_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] dst;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             ones;
    logic             parity;
  } pay_t;

  logic [WIDTH-1:0] res;
  pay_t             res_pay;
  logic             rdy_q;
  logic             adv   [STAGES];
  logic             vld_s [STAGES];
  pay_t             pay_s [STAGES];
  logic             hs;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Opcode decode; flags come from the WIDTH-bit result alone
  always_comb begin
    res = ~in_op1;
    case (in_op)
      3'b000:  res = ~in_op1;
      3'b001:  res = in_op1 & in_op2;
      3'b010:  res = in_op1 | in_op2;
      3'b011:  res = in_op1 ^ in_op2;
      3'b100:  res = ~(in_op1 & in_op2);
      3'b101:  res = ~(in_op1 | in_op2);
      3'b110:  res = ~(in_op1 ^ in_op2);
      default: res = in_op1 & ~in_op2;
    endcase
  end

  assign res_pay = '{dst: res, tag: in_tag, zero: ~|res, ones: &res, parity: ^res};

  // Keeps in_ready low during reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic vld_q, vld_d;
    pay_t pay_q, pay_d;

    // An empty stage always advances, so bubbles collapse
    if (k == STAGES - 1) begin : g_last
      assign adv[k] = ~vld_q | out_ready;
    end else begin : g_mid
      assign adv[k] = ~vld_q | adv[k+1];
    end

    if (k == 0) begin : g_head
      assign vld_d = in_valid & rdy_q;
      assign pay_d = res_pay;
    end else begin : g_tail
      assign vld_d = vld_s[k-1];
      assign pay_d = pay_s[k-1];
    end

    // Stage register: payload only loads when valid data moves in
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        pay_q <= '0;
      end else if (adv[k]) begin
        vld_q <= vld_d;
        if (vld_d) pay_q <= pay_d;
      end
    end

    assign vld_s[k] = vld_q;
    assign pay_s[k] = pay_q;
  end

  assign in_ready   = adv[0] & rdy_q;
  assign out_valid  = vld_s[STAGES-1];
  assign out_dst    = pay_s[STAGES-1].dst;
  assign out_tag    = pay_s[STAGES-1].tag;
  assign out_zero   = pay_s[STAGES-1].zero;
  assign out_ones   = pay_s[STAGES-1].ones;
  assign out_parity = pay_s[STAGES-1].parity;

  assign hs = out_valid & out_ready;

  // Completion count: clear beats a simultaneous handshake, saturate at all ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)              cnt_d = '0;
    else if (hs && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Completion counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: driver pushes expected results on acceptance, a monitor
// pops and compares on every output handshake.
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [63:0] in_op1 = '0, in_op2 = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid, out_ready;
  logic [63:0] out_dst;
  logic [3:0]  out_tag;
  logic        out_zero, out_ones, out_parity;
  logic        cnt_clr = 1'b0;
  logic [31:0] done_cnt;

  logic        c_in_ready, c_out_valid, c_zero, c_ones, c_parity;
  logic [63:0] c_dst;
  logic [3:0]  c_tag;
  logic [3:0]  c_done_cnt;

  logic rand_mode = 1'b0, rnd_bit = 1'b1, rdy_cmd = 1'b1;
  assign out_ready = rand_mode ? rnd_bit : rdy_cmd;

  logic [63:0] cur_exp = '0;
  logic        chk_lat = 1'b0;
  int cyc = 0, checks = 0, errors = 0, hs_cnt = 0, hs_base = 0;

  typedef struct { logic [63:0] dst; logic [3:0] tag; int cyc; } exp_t;
  exp_t sb[$];

  logic_unit_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst), .out_tag(out_tag),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .cnt_clr(cnt_clr), .done_cnt(done_cnt));

  // Narrow-counter copy sharing all stimulus, used for saturation
  logic_unit_pipe #(.CNT_W(4)) u_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_dst(c_dst), .out_tag(c_tag),
    .out_zero(c_zero), .out_ones(c_ones), .out_parity(c_parity),
    .cnt_clr(cnt_clr), .done_cnt(c_done_cnt));

  always #5 clk = ~clk;

  initial forever begin @(posedge clk); cyc++; end

  initial begin
    void'($urandom(32'h00C0FFEE));
    forever begin @(posedge clk); #1; rnd_bit = 1'($urandom_range(0, 1)); end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return a & ~b;
    endcase
  endfunction

  // Monitor: record accepted inputs, compare every output handshake
  initial forever begin
    @(negedge clk);
    if (rst_n && in_valid && in_ready) sb.push_back('{cur_exp, in_tag, cyc});
    if (rst_n && out_valid && out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got tag %0d dst %0h, expected no output", out_tag, out_dst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dst", out_dst, e.dst);
        chk("tag", 64'(out_tag), 64'(e.tag));
        chk("zero", 64'(out_zero), 64'(~|e.dst));
        chk("ones", 64'(out_ones), 64'(&e.dst));
        chk("parity", 64'(out_parity), 64'(^e.dst));
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag, input logic [63:0] exp);
    bit ok = 0;
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag; cur_exp = exp;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL send_timeout: tag %0d not accepted, expected acceptance", tag); end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL drain_timeout: %0d pending, expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  logic [63:0] t_a [10] = '{64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234,
                            64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234,
                            64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234, 64'h0123_4567_89AB_CDEF,
                            64'hF0F0_0000_FFFF_1234};
  logic [63:0] t_b [10] = '{64'h0FF0_FFFF_0000_1234, 64'h0FF0_FFFF_0000_1234, 64'h0FF0_FFFF_0000_1234,
                            64'h0FF0_FFFF_0000_1234, 64'h0FF0_FFFF_0000_1234, 64'h0FF0_FFFF_0000_1234,
                            64'h0FF0_FFFF_0000_1234, 64'h0FF0_FFFF_0000_1234, 64'h0123_4567_89AB_CDEF,
                            64'h0};
  logic [2:0]  t_op [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd1};
  logic [63:0] t_e [10] = '{64'h0F0F_FFFF_0000_EDCB, 64'h00F0_0000_0000_1234, 64'hFFF0_FFFF_FFFF_1234,
                            64'hFF00_FFFF_FFFF_0000, 64'hFF0F_FFFF_FFFF_EDCB, 64'h000F_0000_0000_EDCB,
                            64'h00FF_0000_0000_FFFF, 64'hF000_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'h0};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_dst", out_dst, 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // All opcodes back to back, fixed latency
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) send(t_op[i], t_a[i], t_b[i], 4'(i), t_e[i]);
    drain();
    chk_lat = 1'b0;

    // Backpressure mid-stream: tag 1 is at the output when the stall begins
    fork
      for (int i = 0; i < 6; i++)
        send(3'd3, 64'hFFFF_0000_FFFF_0000, 64'(i), 4'(i), 64'hFFFF_0000_FFFF_0000 | 64'(i));
      begin
        repeat (3) @(posedge clk); #1;
        rdy_cmd = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_dst", out_dst, 64'hFFFF_0000_FFFF_0001);
          chk("stall_tag", 64'(out_tag), 64'd1);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        rdy_cmd = 1'b1;
      end
    join
    drain();

    // Bubbles with random downstream readiness
    hs_base = hs_cnt;
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    rand_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  op;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      send(op, a, b, 4'(i), model(op, a, b));
      @(posedge clk); #1;
    end
    rand_mode = 1'b0;
    drain();
    chk("bubble_done_cnt", 64'(done_cnt), 64'(hs_cnt - hs_base));
    chk("bubble_hs_total", 64'(hs_cnt - hs_base), 64'd20);

    // Saturation: 17 handshakes into a 4-bit counter
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) send(3'd2, 64'(i), 64'h100, 4'(i), 64'h100 | 64'(i));
    drain();
    chk("sat_cnt4", 64'(c_done_cnt), 64'd15);
    chk("cnt32", 64'(done_cnt), 64'd17);

    // Clear coinciding with a handshake
    rdy_cmd = 1'b0;
    send(3'd0, 64'h0, 64'h0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    begin
      bit seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); if (out_valid) seen = 1; end
      chk("clr_out_valid_seen", 64'(seen), 64'd1);
    end
    @(posedge clk); #1;
    rdy_cmd = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_wins_cnt32", 64'(done_cnt), 64'd0);
    chk("clr_wins_cnt4", 64'(c_done_cnt), 64'd0);
    drain();

    // Mid-operation asynchronous reset with two ops in flight
    send(3'd1, 64'hFF, 64'h0F, 4'd3, 64'h0F);
    send(3'd2, 64'hF0, 64'h0F, 4'd4, 64'hFF);
    #2 rst_n = 1'b0;
    #1 chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_out_dst", out_dst, 64'd0);
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    begin
      int seen = 0;
      repeat (6) begin @(negedge clk); if (out_valid) seen++; end
      chk("no_ghost_outputs", 64'(seen), 64'd0);
    end
    chk("post_rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
